// File: rtl/dm_wait_responder.sv
// Data-memory slave for the CPU data port. Every access is held off with DM_Stall for
// LATENCY cycles and then completes with a one-cycle DM_Ack. Storage is an internal word array.
module dm_wait_responder #(
  parameter int unsigned ADDR_W  = 14,
  parameter int unsigned LATENCY = 2,
  parameter int unsigned DATA_W  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  DM_MemRead,
  input  logic [DATA_W/8-1:0]   DM_MemWrite,
  input  logic [31:0]           DM_Adrs,
  input  logic [DATA_W-1:0]     DM_WData,
  output logic [DATA_W-1:0]     DM_RData,
  output logic                  DM_Stall,
  output logic                  DM_Ack,
  output logic                  DM_Conflict
);

  localparam int unsigned NumBytes = DATA_W / 8;
  localparam int unsigned Depth    = 1 << ADDR_W;

  if (LATENCY < 1 || LATENCY > 15) begin : g_latency_check
    $error("dm_wait_responder: LATENCY must be in 1..15");
  end

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  state_e                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [DATA_W-1:0]     wdata_q, wdata_d;
  logic [NumBytes-1:0]   mask_q, mask_d;
  logic                  is_wr_q, is_wr_d;
  logic [DATA_W-1:0]     rbuf_q, rbuf_d;
  logic [DATA_W-1:0]     rdata_q, rdata_d;
  logic                  conflict_q, conflict_d;
  logic                  mem_we;
  logic [DATA_W-1:0]     mem_q [Depth];

  logic              req_wr;
  logic              req;
  logic [ADDR_W-1:0] adrs_idx;
  logic              unused_adrs;

  assign req_wr      = ~&DM_MemWrite;
  assign req         = DM_MemRead | req_wr;
  assign adrs_idx    = DM_Adrs[ADDR_W+1:2];
  // Address bits outside the word index alias onto the same array.
  assign unused_adrs = ^{DM_Adrs[31:ADDR_W+2], DM_Adrs[1:0]};

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    mask_d     = mask_q;
    is_wr_d    = is_wr_q;
    rbuf_d     = rbuf_q;
    rdata_d    = rdata_q;
    conflict_d = 1'b0;
    mem_we     = 1'b0;
    DM_Stall   = 1'b0;
    DM_Ack     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req) begin
          DM_Stall   = 1'b1;
          state_d    = StBusy;
          cnt_d      = 4'(LATENCY - 1);
          addr_d     = adrs_idx;
          wdata_d    = DM_WData;
          mask_d     = DM_MemWrite;
          is_wr_d    = req_wr;
          conflict_d = DM_MemRead & req_wr;
          if (!req_wr) begin
            rbuf_d = mem_q[adrs_idx];
          end
        end
      end
      StBusy: begin
        if (cnt_q != 4'd0) begin
          DM_Stall = 1'b1;
          cnt_d    = cnt_q - 4'd1;
        end else begin
          DM_Ack  = 1'b1;
          state_d = StIdle;
          if (is_wr_q) begin
            mem_we = 1'b1;
          end else begin
            rdata_d = rbuf_q;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= 4'd0;
      addr_q     <= '0;
      wdata_q    <= '0;
      mask_q     <= '1;
      is_wr_q    <= 1'b0;
      rbuf_q     <= '0;
      rdata_q    <= '0;
      conflict_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      mask_q     <= mask_d;
      is_wr_q    <= is_wr_d;
      rbuf_q     <= rbuf_d;
      rdata_q    <= rdata_d;
      conflict_q <= conflict_d;
    end
  end

  // Array is never cleared; reset only suppresses a write that was about to commit.
  always_ff @(posedge clk) begin
    if (mem_we && !rst) begin
      for (int i = 0; i < NumBytes; i++) begin
        if (!mask_q[i]) begin
          mem_q[addr_q][8*i +: 8] <= wdata_q[8*i +: 8];
        end
      end
    end
  end

  assign DM_RData    = rdata_q;
  assign DM_Conflict = conflict_q;

endmodule

// File: tb/tb_dm_wait_responder.sv
// Directed bench: instance A runs with LATENCY=2, instance B with LATENCY=1.
module tb_dm_wait_responder;

  logic        clk;
  logic        rst;
  logic        a_rd, b_rd;
  logic [3:0]  a_we, b_we;
  logic [31:0] a_adrs, b_adrs, a_wdata, b_wdata;
  logic [31:0] a_rdata, b_rdata;
  logic        a_stall, b_stall, a_ack, b_ack, a_conf, b_conf;

  int total = 0;
  int bad   = 0;

  dm_wait_responder #(.ADDR_W(14), .LATENCY(2), .DATA_W(32)) u_dut_a (
    .clk        (clk),
    .rst        (rst),
    .DM_MemRead (a_rd),
    .DM_MemWrite(a_we),
    .DM_Adrs    (a_adrs),
    .DM_WData   (a_wdata),
    .DM_RData   (a_rdata),
    .DM_Stall   (a_stall),
    .DM_Ack     (a_ack),
    .DM_Conflict(a_conf)
  );

  dm_wait_responder #(.ADDR_W(14), .LATENCY(1), .DATA_W(32)) u_dut_b (
    .clk        (clk),
    .rst        (rst),
    .DM_MemRead (b_rd),
    .DM_MemWrite(b_we),
    .DM_Adrs    (b_adrs),
    .DM_WData   (b_wdata),
    .DM_RData   (b_rdata),
    .DM_Stall   (b_stall),
    .DM_Ack     (b_ack),
    .DM_Conflict(b_conf)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Full LATENCY=2 access: acceptance, one busy cycle, completion cycle.
  task automatic acc_a(input logic rd, input logic [3:0] we, input logic [31:0] ad,
                       input logic [31:0] wd, input logic exp_conf);
    cyc();
    a_rd = rd; a_we = we; a_adrs = ad; a_wdata = wd;
    #2;
    chk("a_accept_stall", a_stall, 32'd1);
    chk("a_accept_ack", a_ack, 32'd0);
    cyc();
    a_rd = 1'b0; a_we = 4'hF; a_adrs = 32'h0; a_wdata = 32'h0;
    #2;
    chk("a_busy_stall", a_stall, 32'd1);
    chk("a_busy_ack", a_ack, 32'd0);
    chk("a_conflict", a_conf, {31'd0, exp_conf});
    cyc();
    #2;
    chk("a_done_stall", a_stall, 32'd0);
    chk("a_done_ack", a_ack, 32'd1);
    chk("a_done_conflict", a_conf, 32'd0);
  endtask

  task automatic idle_a();
    cyc();
    a_rd = 1'b0; a_we = 4'hF;
    #2;
    chk("a_idle_stall", a_stall, 32'd0);
    chk("a_idle_ack", a_ack, 32'd0);
  endtask

  // LATENCY=1 access; optionally checks read data visible in the acceptance cycle.
  task automatic acc_b(input logic rd, input logic [3:0] we, input logic [31:0] ad,
                       input logic [31:0] wd, input logic chk_rd, input logic [31:0] exp_rd);
    cyc();
    b_rd = rd; b_we = we; b_adrs = ad; b_wdata = wd;
    #2;
    chk("b_accept_stall", b_stall, 32'd1);
    chk("b_accept_ack", b_ack, 32'd0);
    if (chk_rd) chk("b_rdata", b_rdata, exp_rd);
    cyc();
    b_rd = 1'b0; b_we = 4'hF;
    #2;
    chk("b_done_stall", b_stall, 32'd0);
    chk("b_done_ack", b_ack, 32'd1);
  endtask

  initial begin
    rst = 1'b1;
    a_rd = 1'b0; a_we = 4'hF; a_adrs = 32'h0; a_wdata = 32'h0;
    b_rd = 1'b0; b_we = 4'hF; b_adrs = 32'h0; b_wdata = 32'h0;
    cyc();
    cyc();
    rst = 1'b0;
    #2;
    chk("rst_rdata", a_rdata, 32'h0);
    chk("rst_stall", a_stall, 32'd0);
    chk("rst_ack", a_ack, 32'd0);
    chk("rst_conflict", a_conf, 32'd0);

    // Full-word write then read.
    acc_a(1'b0, 4'b0000, 32'h10, 32'hDEADBEEF, 1'b0);
    acc_a(1'b1, 4'b1111, 32'h10, 32'h0, 1'b0);
    chk("rdata_not_yet", a_rdata, 32'h0);
    idle_a();
    chk("rd_0x10", a_rdata, 32'hDEADBEEF);

    // Byte-lane write merges into the old word; RData holds across the write.
    acc_a(1'b0, 4'b1101, 32'h10, 32'h0000AA00, 1'b0);
    idle_a();
    chk("rdata_hold_wr", a_rdata, 32'hDEADBEEF);
    acc_a(1'b1, 4'b1111, 32'h10, 32'h0, 1'b0);
    idle_a();
    chk("rd_byte_merge", a_rdata, 32'hDEADAAEF);

    // Read and write together: write wins, conflict pulses, RData unchanged.
    acc_a(1'b0, 4'b0000, 32'h20, 32'hFFFFFFFF, 1'b0);
    acc_a(1'b1, 4'b1110, 32'h20, 32'h00000011, 1'b1);
    idle_a();
    chk("rdata_hold_conf", a_rdata, 32'hDEADAAEF);
    acc_a(1'b1, 4'b1111, 32'h20, 32'h0, 1'b0);
    idle_a();
    chk("rd_conf_write", a_rdata, 32'hFFFFFF11);

    // Reset in the completion cycle of a write drops that write.
    acc_a(1'b0, 4'b0000, 32'h30, 32'h12345678, 1'b0);
    idle_a();
    cyc();
    a_rd = 1'b0; a_we = 4'b0000; a_adrs = 32'h30; a_wdata = 32'hCAFEF00D;
    #2;
    chk("rstw_accept_stall", a_stall, 32'd1);
    cyc();
    a_we = 4'hF;
    cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    #2;
    chk("rstw_stall", a_stall, 32'd0);
    chk("rstw_ack", a_ack, 32'd0);
    chk("rstw_conflict", a_conf, 32'd0);
    chk("rstw_rdata", a_rdata, 32'h0);
    acc_a(1'b1, 4'b1111, 32'h30, 32'h0, 1'b0);
    idle_a();
    chk("rd_after_rst", a_rdata, 32'h12345678);

    // Aliased address, read accepted right after the write ack.
    acc_a(1'b0, 4'b0000, 32'h00010004, 32'hA5A55A5A, 1'b0);
    acc_a(1'b1, 4'b1111, 32'h00000004, 32'h0, 1'b0);
    idle_a();
    chk("rd_alias", a_rdata, 32'hA5A55A5A);

    // LATENCY=1: preload, then back-to-back reads alternate stall/ack.
    acc_b(1'b0, 4'b0000, 32'h0, 32'h11110000, 1'b0, 32'h0);
    acc_b(1'b0, 4'b0000, 32'h4, 32'h22220004, 1'b0, 32'h0);
    acc_b(1'b0, 4'b0000, 32'h8, 32'h33330008, 1'b0, 32'h0);
    acc_b(1'b1, 4'b1111, 32'h0, 32'h0, 1'b1, 32'h0);
    acc_b(1'b1, 4'b1111, 32'h4, 32'h0, 1'b1, 32'h11110000);
    acc_b(1'b1, 4'b1111, 32'h8, 32'h0, 1'b1, 32'h22220004);
    cyc();
    #2;
    chk("b_idle_stall", b_stall, 32'd0);
    chk("b_rd_0x8", b_rdata, 32'h33330008);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
